// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler.
// Byte frame type, scheduler states and the word-width constant.
package uart_tx_sched_pkg;

    typedef logic [7:0] dataframe_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        NEXT
    } tx_sched_state_t;

    localparam int TX_SCHED_WORD_W = 16;

    // Pick one byte of a word: 0 = low byte, 1 = high byte.
    function automatic dataframe_t word_byte(
        input logic [TX_SCHED_WORD_W-1:0] w,
        input logic                       sel
    );
        return sel ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter for the UART transmit scheduler.
// Combinational; the pointer is owned and updated by the caller.
module uart_tx_sched_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan from rr_ptr upward (wrapping) and take the first valid request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found && enable) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign any_req = enable & (|req);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ words.
// Optional macro UART_TX_SCHED_TIMEOUT_EN adds the TIMEOUT_ERR watchdog.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = 15
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [NUM_REQ-1:0]                      REQ_VALID,
    input  logic [NUM_REQ-1:0][TX_SCHED_WORD_W-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]                      REQ_TWO_BYTE,
    output logic [NUM_REQ-1:0]                      REQ_READY,
    output dataframe_t                              TX_P_DATA,
    output logic                                    TX_DATA_VALID,
    input  logic                                    TX_BUSY,
    output logic [IDX_W-1:0]                        GNT_IDX,
`ifdef UART_TX_SCHED_TIMEOUT_EN
    output logic                                    TIMEOUT_ERR,
`endif
    output logic                                    SCHED_BUSY
);

    tx_sched_state_t            state;
    logic [IDX_W-1:0]           rr_ptr;
    logic                       byte_cnt;
    logic [TX_SCHED_WORD_W-1:0] word_q;
    logic                       two_q;

    logic                       arb_en;
    logic [NUM_REQ-1:0]         arb_gnt;
    logic [IDX_W-1:0]           arb_idx;
    logic                       arb_any;
    logic [IDX_W-1:0]           rr_next;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    assign arb_en     = (state == IDLE);
    assign rr_next    = IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
    assign REQ_READY  = arb_gnt;
    assign SCHED_BUSY = (state != IDLE);

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (REQ_VALID),
        .rr_ptr  (rr_ptr),
        .enable  (arb_en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // Scheduler FSM: grant, strobe each byte, then follow Busy high and low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            byte_cnt      <= 1'b0;
            word_q        <= '0;
            two_q         <= 1'b0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            GNT_IDX       <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt        <= '0;
            TIMEOUT_ERR   <= 1'b0;
`endif
        end else begin
            TX_DATA_VALID <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            TIMEOUT_ERR   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        rr_ptr        <= rr_next;
                        GNT_IDX       <= arb_idx;
                        word_q        <= REQ_DATA[arb_idx];
                        two_q         <= REQ_TWO_BYTE[arb_idx];
                        byte_cnt      <= 1'b0;
                        TX_P_DATA     <= word_byte(REQ_DATA[arb_idx], 1'b0);
                        TX_DATA_VALID <= !TX_BUSY;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobe is a single ISSUE cycle; stall it while Busy.
                    if (TX_DATA_VALID) begin
                        state <= WAIT_HI;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else begin
                        TX_DATA_VALID <= !TX_BUSY;
                    end
                end
                WAIT_HI: begin
                    if (TX_BUSY) begin
                        state <= WAIT_LO;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        TX_P_DATA   <= '0;
                        TIMEOUT_ERR <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (two_q && !byte_cnt) begin
                        // byte_cnt is 0 here, so this selects the high byte.
                        byte_cnt      <= 1'b1;
                        TX_P_DATA     <= word_byte(word_q, !byte_cnt);
                        TX_DATA_VALID <= !TX_BUSY;
                        state         <= ISSUE;
                    end else begin
                        TX_P_DATA <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural transmitter.
// Build with UART_TX_SCHED_TIMEOUT_EN to also cover the watchdog.
module tb_uart_tx_sched;

    localparam int N     = 2;
    localparam int FRAME = 10;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] b;
    } exp_t;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic [N-1:0]       REQ_VALID;
    logic [N-1:0][15:0] REQ_DATA;
    logic [N-1:0]       REQ_TWO_BYTE;
    logic [N-1:0]       REQ_READY;
    logic [7:0]         TX_P_DATA;
    logic               TX_DATA_VALID;
    logic               TX_BUSY;
    logic               GNT_IDX;
    logic               SCHED_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic               TIMEOUT_ERR;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t byte_q[$];
    int   gnt_q[$];

    logic       cap_pend;
    logic [7:0] strobe_byte;
    int         busy_cnt;
    bit         tx_en = 1'b1;
    int         strobes = 0;

    uart_tx_sched #(
        .NUM_REQ (N),
        .TIMEOUT (15)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (REQ_VALID),
        .REQ_DATA      (REQ_DATA),
        .REQ_TWO_BYTE  (REQ_TWO_BYTE),
        .REQ_READY     (REQ_READY),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (TX_BUSY),
        .GNT_IDX       (GNT_IDX),
`ifdef UART_TX_SCHED_TIMEOUT_EN
        .TIMEOUT_ERR   (TIMEOUT_ERR),
`endif
        .SCHED_BUSY    (SCHED_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transmitter model: captures one cycle after the strobe, then Busy.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            TX_BUSY  = 1'b0;
            cap_pend = 1'b0;
            busy_cnt = 0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) TX_BUSY = 1'b0;
            end
            if (cap_pend) begin
                cap_pend = 1'b0;
                chk("hold", TX_P_DATA, strobe_byte);
                if (byte_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte actual=%0h required=none",
                             TX_P_DATA);
                end else begin
                    e = byte_q.pop_front();
                    chk("tx_byte", TX_P_DATA, e.b);
                    chk("gnt_idx", GNT_IDX, e.idx);
                end
                if (tx_en) begin
                    TX_BUSY  = 1'b1;
                    busy_cnt = FRAME;
                end
            end
            if (TX_DATA_VALID) begin
                strobes++;
                chk("strobe_busy", TX_BUSY, 0);
                strobe_byte = TX_P_DATA;
                cap_pend    = 1'b1;
            end
        end
    end

    // Ready monitor: every accept pulse must match the expected winner.
    always @(negedge CLK) begin
        int g;
        if (RST && (|REQ_READY)) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ready actual=%0h required=none", REQ_READY);
            end else begin
                g = gnt_q.pop_front();
                chk("ready", REQ_READY, 32'(1) << g);
                chk("ready_valid", REQ_READY & REQ_VALID, REQ_READY);
            end
        end
    end

    task automatic push_b(input int i, input logic [7:0] b);
        exp_t e;
        e.idx = 8'(i);
        e.b   = b;
        byte_q.push_back(e);
    endtask

    task automatic send(input int i, input logic [15:0] d, input logic two,
                        input logic drop, input logic scramble);
        int n;
        REQ_DATA[i]     = d;
        REQ_TWO_BYTE[i] = two;
        REQ_VALID[i]    = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!REQ_READY[i] && n < 200);
        if (!REQ_READY[i]) begin
            checks++;
            errors++;
            $display("FAIL ready_wait actual=0 required=1 req=%0d", i);
        end
        @(posedge CLK);
        #1;
        if (drop) REQ_VALID[i] = 1'b0;
        if (scramble) REQ_DATA[i] = ~d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((SCHED_BUSY || TX_BUSY || byte_q.size() != 0) && n < 2000);
        chk(name, SCHED_BUSY, 0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_data"}, TX_P_DATA, 0);
        chk({name, "_strobe"}, TX_DATA_VALID, 0);
        chk({name, "_gnt"}, GNT_IDX, 0);
        chk({name, "_busy"}, SCHED_BUSY, 0);
        chk({name, "_ready"}, REQ_READY, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        REQ_VALID    = '0;
        REQ_DATA     = '0;
        REQ_TWO_BYTE = '0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        RST = 1'b1;
        repeat (2) tick();

        // Single 1-byte word from requester 0.
        s0 = strobes;
        gnt_q.push_back(0);
        push_b(0, 8'hA5);
        send(0, 16'h00A5, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!TX_BUSY && n < 100) begin tick(); n++; end
        n = 0;
        while (TX_BUSY && n < 100) begin tick(); n++; end
        chk("busy_at_fall", SCHED_BUSY, 1);
        tick();
        chk("busy_after_fall", SCHED_BUSY, 0);
        wait_idle("idle1");
        chk("strobes1", strobes - s0, 1);

        // 2-byte word from requester 1: low byte first.
        s0 = strobes;
        gnt_q.push_back(1);
        push_b(1, 8'hEF);
        push_b(1, 8'hBE);
        send(1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        wait_idle("idle2");
        chk("strobes2", strobes - s0, 2);

        // Contention: both valid continuously, rr_ptr is 0 here.
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back(0);
            push_b(0, 8'h10 + 8'(k));
            gnt_q.push_back(1);
            push_b(1, 8'h30 + 8'(k));
            push_b(1, 8'h20 + 8'(k));
        end
        fork
            for (int k = 0; k < 4; k++)
                send(0, {8'hF0 + 8'(k), 8'h10 + 8'(k)}, 1'b0,
                     k == 3, 1'b0);
            for (int k = 0; k < 4; k++)
                send(1, {8'h20 + 8'(k), 8'h30 + 8'(k)}, 1'b1,
                     k == 3, 1'b0);
        join
        wait_idle("idle3");

        // Hold check: data changes right after the accept.
        gnt_q.push_back(0);
        push_b(0, 8'hC5);
        push_b(0, 8'h5A);
        send(0, 16'h5AC5, 1'b1, 1'b1, 1'b1);
        wait_idle("idle4");

        // Reset during the second byte of a 2-byte word.
        s0 = strobes;
        gnt_q.push_back(1);
        push_b(1, 8'hD4);
        push_b(1, 8'hC3);
        send(1, 16'hC3D4, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!(strobes == s0 + 2 && TX_BUSY) && n < 200) begin
            tick();
            n++;
        end
        chk("mid_frame_busy", SCHED_BUSY, 1);
        RST = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) tick();
        RST = 1'b1;
        tick();

        // After reset rr_ptr is 0 again: requester 0 wins first.
        gnt_q.push_back(0);
        push_b(0, 8'h42);
        gnt_q.push_back(1);
        push_b(1, 8'h76);
        push_b(1, 8'h98);
        fork
            send(0, 16'h0042, 1'b0, 1'b1, 1'b0);
            send(1, 16'h9876, 1'b1, 1'b1, 1'b0);
        join
        wait_idle("idle5");

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Transmitter never raises Busy: one strobe, then TIMEOUT_ERR.
        tx_en = 1'b0;
        s0 = strobes;
        gnt_q.push_back(0);
        push_b(0, 8'h88);
        send(0, 16'h7788, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (strobes == s0 && n < 100) begin tick(); n++; end
        n = 0;
        while (!TIMEOUT_ERR && n < 100) begin tick(); n++; end
        chk("timeout_cycles", n, 15);
        chk("timeout_idle", SCHED_BUSY, 0);
        tick();
        chk("timeout_pulse", TIMEOUT_ERR, 0);
        repeat (20) tick();
        chk("timeout_strobes", strobes - s0, 1);
        tx_en = 1'b1;
`endif

        chk("byte_q_empty", byte_q.size(), 0);
        chk("gnt_q_empty", gnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmitter between NUM_REQ requesters, e.g. the register-file read path and the ALU result path in the system controller.
- Each requester hands over a 1- or 2-byte word with a valid/ready handshake.
- The block serialises the word into byte frames, issues them to the transmitter one at a time, and tracks the transmitter's Busy signal to know when each frame has finished.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDX_W, $clog2(NUM_REQ) (minimum 1), width of the grant index.
- TIMEOUT, 15, cycles allowed for the transmitter to raise Busy after an issue. Used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester word valid.
- REQ_DATA  in  NUM_REQ x 16  per-requester word; low byte is sent first.
- REQ_TWO_BYTE  in  NUM_REQ  1 = send both bytes, 0 = low byte only.
- REQ_READY  out  NUM_REQ  one-hot accept pulse.
- TX_P_DATA  out  dataframe_t  byte to the transmitter.
- TX_DATA_VALID  out  1  one-cycle issue strobe to the transmitter.
- TX_BUSY  in  1  transmitter Busy.
- GNT_IDX  out  IDX_W  index of the requester currently being served.
- SCHED_BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-low) drives every output to 0 and clears all internal state: state=IDLE, rr_ptr=0, byte_cnt=0, held word=0.
- Handshake
  - A transfer happens on a cycle with REQ_VALID[i]=1 and REQ_READY[i]=1.
  - REQ_READY is asserted only in IDLE, for exactly one cycle, to the requester that wins arbitration.
  - In that same cycle the block latches REQ_DATA[i] and REQ_TWO_BYTE[i] into internal registers.
  - Requesters must hold VALID and DATA stable until they see READY.
- Arbitration
  - Round-robin starting at rr_ptr; the first i in rr_ptr, rr_ptr+1, ... (mod NUM_REQ) with REQ_VALID[i]=1 wins.
  - On grant, rr_ptr becomes (winner+1) mod NUM_REQ.
  - If no requester is valid, rr_ptr is unchanged.
- State machine
  - IDLE: if any REQ_VALID, grant, latch the word, set byte_cnt=0 and go to ISSUE.
  - ISSUE: drive TX_P_DATA with the byte selected by byte_cnt (0 = bits 7:0, 1 = bits 15:8) and pulse TX_DATA_VALID=1; go to WAIT_HI.
  - WAIT_HI: TX_DATA_VALID=0 while TX_P_DATA is held. When TX_BUSY=1, go to WAIT_LO.
  - WAIT_LO: when TX_BUSY=0, go to NEXT.
  - NEXT: if the latched two-byte flag is set and byte_cnt=0, set byte_cnt=1 and go to ISSUE; otherwise go to IDLE.
- TX_P_DATA is registered and stays stable from ISSUE until WAIT_LO is exited. The transmitter captures the byte one cycle after the strobe, so the hold is mandatory.
- TX_P_DATA is 0 in IDLE.
- ISSUE is entered only when TX_BUSY=0. If TX_BUSY=1 on entry to ISSUE, the block stalls in ISSUE without strobing until it falls.
- GNT_IDX is valid and stable from the grant until the return to IDLE.
- Latency
  - Grant to first strobe: 1 cycle.
  - A 2-byte word takes 2 full frames plus 3 cycles of overhead per byte.
- Boundary conditions
  - A requester that drops VALID before being granted is simply not served.
  - A requester that re-asserts VALID during a transfer is queued by the next IDLE arbitration.
  - Simultaneous requests from all requesters are served in round-robin order, with no requester starved.
  - Reset mid-frame returns to IDLE immediately; the transmitter is reset by the same RST.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined
  - Adds output TIMEOUT_ERR (1 bit, reset 0) and a counter of width $clog2(TIMEOUT+1).
  - In WAIT_HI, if TX_BUSY stays 0 for TIMEOUT cycles, the block abandons the word: returns to IDLE, pulses TIMEOUT_ERR for 1 cycle, and does not send any remaining byte.
- Undefined: no port and no counter; WAIT_HI waits indefinitely.

Decomposition:
- SYS_PKG: dataframe_t (shared), plus a new enum tx_sched_state_t {IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT} and the constant TX_SCHED_WORD_W=16.
- Sub-module rr_arbiter (parameter NUM_REQ)
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational, plus the pointer update driven by the top level.

Test Plan:
- Single 1-byte word: REQ_VALID[0], REQ_DATA=16'h00A5, TWO_BYTE=0 → one READY[0] pulse, one strobe with TX_P_DATA=8'hA5, SCHED_BUSY falls 1 cycle after TX_BUSY falls.
- 2-byte word: REQ_DATA[1]=16'hBEEF, TWO_BYTE=1 → strobes carry 8'hEF then 8'hBE, the second only after TX_BUSY has fallen. The serial line decodes both bytes.
- Contention: both requesters valid continuously for 4 words each → grant order 0,1,0,1,…, with GNT_IDX stable during each word.
- Hold check: change REQ_DATA immediately after READY → the transmitted byte equals the latched value. TX_P_DATA is stable throughout WAIT_HI.
- Reset mid-frame: assert RST during the second byte of a 2-byte word → all outputs 0 and state IDLE. After release, a new request is served starting with its low byte.
- With UART_TX_SCHED_TIMEOUT_EN and TX_BUSY tied 0: a request produces exactly one strobe, then TIMEOUT_ERR pulses after 15 cycles and the block returns to IDLE.
